// File: rtl/insn_fetch_unit_if.sv
// Fetch unit bus bundle: program ROM read port plus the instruction
// handshake (and loop-skip requests) toward the decode/execute stage.
interface insn_fetch_unit_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_req;
  logic                  rom_ack;
  logic [3:0]            rom_data;
  logic [3:0]            insn;
  logic                  insn_valid;
  logic                  insn_ready;
  logic                  skip_fwd;
  logic                  skip_back;

  // fetch unit side
  modport master (
    output rom_addr, rom_req, insn, insn_valid,
    input  rom_ack, rom_data, insn_ready, skip_fwd, skip_back
  );

  // ROM + execute stage side
  modport slave (
    input  rom_addr, rom_req, insn, insn_valid,
    output rom_ack, rom_data, insn_ready, skip_fwd, skip_back
  );
endinterface

// File: rtl/insn_fetch_unit.sv
// Instruction fetch and bracket-matching loop-skip sequencer.
// Walks IP through program ROM, presents one 4-bit instruction at a time,
// and scans forward/backward for the matching bracket on loop skips.
module insn_fetch_unit #(
  parameter int         ADDR_WIDTH  = 12,
  parameter int         DEPTH_WIDTH = 8,
  parameter logic [3:0] LOOP_OPEN   = 4'hA,
  parameter logic [3:0] LOOP_CLOSE  = 4'hB,
  parameter logic [3:0] HALT_CODE   = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  insn_fetch_unit_if.master  bus,
  output logic               busy,
  output logic               halted,
  output logic               error
);
  typedef enum logic [2:0] {
    IDLE, FETCH, PRESENT, SKIP_F, SKIP_B, HALT, ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  IP_MAX    = '1;
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  ip;
  logic [DEPTH_WIDTH-1:0] depth;
  logic [DEPTH_WIDTH-1:0] depth_n;
  logic                   depth_ovf;
  logic                   ack;
  logic [3:0]             nest_code;
  logic [3:0]             unnest_code;

  // ROM address comes straight from IP, so it is stable for the whole request
  assign bus.rom_addr = ip;
  // acks outside an outstanding request are ignored
  assign ack = bus.rom_ack & bus.rom_req;

  // scan depth after the current ack: the bracket we came from nests deeper,
  // the opposite bracket unwinds one level
  always_comb begin
    nest_code   = (state == SKIP_B) ? LOOP_CLOSE : LOOP_OPEN;
    unnest_code = (state == SKIP_B) ? LOOP_OPEN  : LOOP_CLOSE;
    depth_n     = depth;
    depth_ovf   = 1'b0;
    if (bus.rom_data == nest_code) begin
      depth_n   = depth + 1'b1;
      depth_ovf = (depth == DEPTH_MAX);
    end else if (bus.rom_data == unnest_code) begin
      depth_n   = depth - 1'b1;
    end
  end

  // sequencer FSM; every output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ip             <= '0;
      depth          <= '0;
      bus.insn       <= '0;
      bus.insn_valid <= 1'b0;
      bus.rom_req    <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      error          <= 1'b0;
    end else if (start) begin
      // restart abandons any outstanding ROM request
      state          <= FETCH;
      ip             <= '0;
      depth          <= '0;
      bus.insn_valid <= 1'b0;
      bus.rom_req    <= 1'b1;
      busy           <= 1'b1;
      halted         <= 1'b0;
      error          <= 1'b0;
    end else begin
      case (state)
        FETCH: if (ack) begin
          bus.rom_req <= 1'b0;
          if (bus.rom_data == HALT_CODE) begin
            state  <= HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state          <= PRESENT;
            bus.insn       <= bus.rom_data;
            bus.insn_valid <= 1'b1;
          end
        end

        PRESENT: begin
          if (bus.skip_fwd && bus.insn == LOOP_OPEN) begin
            bus.insn_valid <= 1'b0;
            depth          <= DEPTH_ONE;
            if (ip == IP_MAX) begin
              // nothing left to scan: the open can never be matched
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= SKIP_F;
              ip          <= ip + 1'b1;
              bus.rom_req <= 1'b1;
            end
          end else if (bus.skip_back && bus.insn == LOOP_CLOSE) begin
            bus.insn_valid <= 1'b0;
            depth          <= DEPTH_ONE;
            if (ip == '0) begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= SKIP_B;
              ip          <= ip - 1'b1;
              bus.rom_req <= 1'b1;
            end
          end else if (bus.insn_ready) begin
            // plain transfer; IP wraps naturally at the top of ROM
            bus.insn_valid <= 1'b0;
            state          <= FETCH;
            ip             <= ip + 1'b1;
            bus.rom_req    <= 1'b1;
          end
        end

        SKIP_F, SKIP_B: if (ack) begin
          if (depth_ovf) begin
            state       <= ERROR;
            error       <= 1'b1;
            busy        <= 1'b0;
            bus.rom_req <= 1'b0;
          end else if (depth_n == '0) begin
            // matched: resume on the word after the bracket, request stays up
            depth <= '0;
            ip    <= ip + 1'b1;
            state <= FETCH;
          end else if ((state == SKIP_F && ip == IP_MAX) ||
                       (state == SKIP_B && ip == '0)) begin
            state       <= ERROR;
            error       <= 1'b1;
            busy        <= 1'b0;
            bus.rom_req <= 1'b0;
          end else begin
            depth <= depth_n;
            ip    <= (state == SKIP_F) ? ip + 1'b1 : ip - 1'b1;
          end
        end

        // IDLE, HALT and ERROR hold until start or reset
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed bench for insn_fetch_unit: a 12-bit instance for the main flows
// and a 1-bit-address instance for the run-off-ROM case.
module tb_insn_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, halted0, error0, busy1, halted1, error1;
  logic [3:0] rom0 [16];
  logic [3:0] rom1 [2];
  int   cnt0 = 0;
  int   dly0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acks;

  always #5 clk = ~clk;

  insn_fetch_unit_if #(.ADDR_WIDTH(12)) b0();
  insn_fetch_unit_if #(.ADDR_WIDTH(1))  b1();

  insn_fetch_unit #(.ADDR_WIDTH(12)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(b0),
    .busy(busy0), .halted(halted0), .error(error0)
  );
  insn_fetch_unit #(.ADDR_WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(b1),
    .busy(busy1), .halted(halted1), .error(error1)
  );

  // ROM models: u0 has a programmable ack latency, u1 is zero-wait
  always @(posedge clk) begin
    if (b0.rom_req && !b0.rom_ack) cnt0 <= cnt0 + 1;
    else cnt0 <= 0;
  end
  assign b0.rom_ack  = b0.rom_req && (cnt0 >= dly0);
  assign b0.rom_data = rom0[b0.rom_addr[3:0]];
  assign b1.rom_ack  = b1.rom_req;
  assign b1.rom_data = rom1[b1.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_rom();
    foreach (rom0[i]) rom0[i] = 4'h0;
  endtask

  // start and, with a zero-wait ROM, arrive in PRESENT on IP 0
  task automatic start_pulse();
    start0 = 1'b1; tick(); start0 = 1'b0; tick();
  endtask

  // accept the presented insn and arrive at the next one
  task automatic accept();
    b0.insn_ready = 1'b1; tick(); b0.insn_ready = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    b0.insn_ready = 1'b0; b0.skip_fwd = 1'b0; b0.skip_back = 1'b0;
    b1.insn_ready = 1'b0; b1.skip_fwd = 1'b0; b1.skip_back = 1'b0;
    clr_rom();
    rom1[0] = 4'hA; rom1[1] = 4'h1;
    #12;
    // reset state
    chk("rst_busy", busy0, 0); chk("rst_halted", halted0, 0);
    chk("rst_error", error0, 0); chk("rst_req", b0.rom_req, 0);
    chk("rst_valid", b0.insn_valid, 0); chk("rst_insn", b0.insn, 0);
    chk("rst_addr", b0.rom_addr, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_no_req", b0.rom_req, 0);

    // program 1,2,3,F streamed with ready held high
    rom0[0] = 4'h1; rom0[1] = 4'h2; rom0[2] = 4'h3; rom0[3] = 4'hF;
    b0.insn_ready = 1'b1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("c1_req", b0.rom_req, 1); chk("c1_valid", b0.insn_valid, 0);
    chk("c1_busy", busy0, 1);
    tick();
    chk("c2_valid", b0.insn_valid, 1); chk("c2_insn", b0.insn, 4'h1);
    chk("c2_req", b0.rom_req, 0);
    tick();
    chk("c3_valid", b0.insn_valid, 0); chk("c3_addr", b0.rom_addr, 1);
    tick();
    chk("c4_insn", b0.insn, 4'h2); chk("c4_valid", b0.insn_valid, 1);
    tick(); tick();
    chk("c6_insn", b0.insn, 4'h3); chk("c6_valid", b0.insn_valid, 1);
    tick(); tick();
    chk("halt_halted", halted0, 1); chk("halt_busy", busy0, 0);
    chk("halt_valid", b0.insn_valid, 0); chk("halt_req", b0.rom_req, 0);
    chk("halt_addr", b0.rom_addr, 3);
    b0.insn_ready = 1'b0;

    // forward skip over a nested loop
    clr_rom();
    rom0[0] = 4'hA; rom0[1] = 4'h1; rom0[2] = 4'hA; rom0[3] = 4'h2;
    rom0[4] = 4'hB; rom0[5] = 4'hB; rom0[6] = 4'h5;
    start_pulse();
    chk("sf_halt_clr", halted0, 0); chk("sf_open", b0.insn, 4'hA);
    b0.skip_fwd = 1'b1; tick(); b0.skip_fwd = 1'b0;
    chk("sf_scan_addr", b0.rom_addr, 1); chk("sf_valid_drop", b0.insn_valid, 0);
    acks = 0;
    for (int i = 0; i < 30 && !b0.insn_valid; i++) begin
      if (b0.rom_req && b0.rom_ack) acks++;
      tick();
    end
    chk("sf_accesses", acks, 6); chk("sf_insn", b0.insn, 4'h5);
    chk("sf_addr", b0.rom_addr, 6);

    // ignored skip, then backward skip
    clr_rom();
    rom0[0] = 4'h7; rom0[1] = 4'hA; rom0[2] = 4'h1; rom0[3] = 4'hB; rom0[4] = 4'h4;
    start_pulse();
    chk("sb_first", b0.insn, 4'h7);
    b0.skip_back = 1'b1; tick(); b0.skip_back = 1'b0;
    chk("nomatch_valid", b0.insn_valid, 1); chk("nomatch_addr", b0.rom_addr, 0);
    accept(); chk("sb_open", b0.insn, 4'hA);
    accept(); chk("sb_body", b0.insn, 4'h1);
    accept(); chk("sb_close", b0.insn, 4'hB); chk("sb_close_addr", b0.rom_addr, 3);
    b0.skip_back = 1'b1; tick(); b0.skip_back = 1'b0;
    chk("sb_scan0", b0.rom_addr, 2);
    tick(); chk("sb_scan1", b0.rom_addr, 1);
    tick(); chk("sb_resume", b0.rom_addr, 2);
    tick(); chk("sb_insn", b0.insn, 4'h1); chk("sb_insn_valid", b0.insn_valid, 1);
    accept(); chk("sb_again", b0.rom_addr, 3); chk("sb_again_insn", b0.insn, 4'hB);

    // handshake hold with slow ROM and stalled consumer
    clr_rom();
    rom0[0] = 4'h6; rom0[1] = 4'h7;
    dly0 = 3;
    start0 = 1'b1; tick(); start0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", b0.rom_req, 1); chk("wait_addr", b0.rom_addr, 0);
      chk("wait_valid", b0.insn_valid, 0);
      tick();
    end
    chk("wait_ack", b0.rom_ack, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_insn", b0.insn, 4'h6); chk("hold_valid", b0.insn_valid, 1);
      chk("hold_addr", b0.rom_addr, 0);
      tick();
    end
    b0.insn_ready = 1'b1; tick(); b0.insn_ready = 1'b0;
    chk("hold_adv", b0.rom_addr, 1); chk("hold_drop", b0.insn_valid, 0);
    dly0 = 0;

    // unmatched open on the tiny ROM
    start1 = 1'b1; tick(); start1 = 1'b0; tick();
    chk("um_insn", b1.insn, 4'hA);
    b1.skip_fwd = 1'b1; tick(); b1.skip_fwd = 1'b0;
    tick();
    chk("um_error", error1, 1); chk("um_busy", busy1, 0); chk("um_req", b1.rom_req, 0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("um_err_clr", error1, 0); chk("um_refetch", b1.rom_addr, 0);
    chk("um_refetch_req", b1.rom_req, 1);
    tick(); chk("um_reinsn", b1.insn, 4'hA);

    // skip back on a close at IP 0
    clr_rom();
    rom0[0] = 4'hB;
    start_pulse();
    b0.skip_back = 1'b1; tick(); b0.skip_back = 1'b0;
    chk("sb0_error", error0, 1); chk("sb0_valid", b0.insn_valid, 0);

    // asynchronous reset in the middle of a backward scan
    clr_rom();
    rom0[0] = 4'hA; rom0[1] = 4'h2; rom0[2] = 4'hB;
    start_pulse(); accept(); accept();
    chk("ar_close", b0.insn, 4'hB);
    b0.skip_back = 1'b1; tick(); b0.skip_back = 1'b0;
    chk("ar_scanning", b0.rom_req, 1); chk("ar_addr", b0.rom_addr, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_req", b0.rom_req, 0); chk("ar_busy", busy0, 0);
    chk("ar_insn", b0.insn, 0); chk("ar_addr0", b0.rom_addr, 0);
    chk("ar_err", error0, 0);
    #2 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("ar_idle_req", b0.rom_req, 0); chk("ar_idle_busy", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/insn_fetch_unit.md
# insn_fetch_unit

Instruction fetch and loop-skip sequencer sitting directly upstream of the 4-bit-to-one-hot opcode decoder. It walks an instruction pointer through program ROM and presents one 4-bit instruction at a time to the decode/execute stage over a valid/ready handshake. It also performs the bracket-matching scans needed for loop entry skip and loop-back jumps.

## Interface
- ADDR_WIDTH, 12, instruction pointer / ROM address width
- DEPTH_WIDTH, 8, bracket nesting counter width
- LOOP_OPEN, 4'hA, loop-open instruction code
- LOOP_CLOSE, 4'hB, loop-close instruction code
- HALT_CODE, 4'hF, halt instruction code

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  synchronous restart pulse: IP=0, begin fetching
- RomAddr  out  ADDR_WIDTH  ROM address (= IP)
- RomReq  out  1  ROM read request
- RomAck  in  1  ROM data valid this cycle
- RomData  in  4  ROM read data
- Insn  out  4  presented instruction (to decoder)
- InsnValid  out  1  Insn valid
- InsnReady  in  1  execute stage consumes Insn
- SkipFwd  in  1  with InsnValid on LOOP_OPEN: skip to after matching close
- SkipBack  in  1  with InsnValid on LOOP_CLOSE: jump to after matching open
- Busy  out  1  not in IDLE/HALT/ERROR
- Halted  out  1  HALT_CODE fetched
- Error  out  1  scan ran off ROM or depth overflow

## Operation
- States: IDLE, FETCH, PRESENT, SKIP_F, SKIP_B, HALT, ERROR.
- Reset: state IDLE; IP=0, Insn=0, InsnValid=0, RomReq=0, Busy=0, Halted=0, Error=0, depth=0.
- Start, from any state, takes priority over everything else. It sets IP=0, depth=0, Halted=0, Error=0, InsnValid=0 and moves to FETCH. An outstanding ROM request is abandoned.
- FETCH: RomReq=1, RomAddr=IP. On RomAck:
  - RomData==HALT_CODE → HALT.
  - Otherwise Insn<=RomData → PRESENT.
- PRESENT: InsnValid=1, Insn stable. Evaluated in priority order:
  - SkipFwd & Insn==LOOP_OPEN → depth=1, IP+1, SKIP_F.
  - SkipBack & Insn==LOOP_CLOSE → depth=1, IP−1, SKIP_B.
  - InsnReady → IP+1, FETCH.
  - A skip request whose bracket does not match Insn is ignored. It is treated as plain InsnReady only if InsnReady is also high.
- SKIP_F: one ROM read per step (RomReq/RomAck as in FETCH). On each ack, depth changes as follows:
  - LOOP_OPEN: depth+1.
  - LOOP_CLOSE: depth−1.
  - Anything else, including HALT_CODE: unchanged.
  - New depth 0 → IP+1, FETCH. Otherwise IP+1, stay.
- SKIP_B: symmetric. LOOP_CLOSE: depth+1; LOOP_OPEN: depth−1. New depth 0 → IP+1, FETCH (resume after matching open). Otherwise IP−1, stay.
- Boundaries:
  - In normal FETCH/PRESENT, IP wraps from max to 0.
  - In SKIP_F at IP=max with depth still nonzero after the ack → ERROR.
  - SKIP_B needing IP−1 from 0 → ERROR.
  - Depth increment from all-ones → ERROR.
  - SkipBack on the close at IP=0 → ERROR immediately.
- HALT: Halted=1, InsnValid=0, RomReq=0; held until Start or reset.
- ERROR: Error=1, InsnValid=0, RomReq=0; held until Start or reset.

## Timing
- All outputs are registered except RomAddr, which is driven directly from the IP register.
- RomReq is high the cycle after entry to FETCH/SKIP_* and stays high through the ack cycle. RomAddr is stable while RomReq=1.
- RomData is sampled only on RomAck=1 with RomReq=1; an ack without request is ignored.
- Start at cycle 0 with zero-wait ROM (ack in the first RomReq cycle): RomReq at cycle 1, InsnValid at cycle 2.
- Steady-state throughput with zero-wait ROM and InsnReady held high: one instruction per 2 cycles.
- Handshake transfer happens on the InsnValid&InsnReady edge. InsnValid drops the following cycle.
- A skip costs one ROM access per scanned word.
- Reset asserted mid-operation clears everything immediately, asynchronously. The first fetch after release occurs only on Start.

## Test plan
- ROM {1,2,3,F} at 0..3, Start, InsnReady=1, zero-wait ROM → Insn sequence 1,2,3; then Halted=1, Busy=0, InsnValid=0, RomAddr=3.
- ROM {A,1,A,2,B,B,5}, SkipFwd at IP=0 → 6 scan accesses (IP1..6 touched, ends at IP5 match); next presented Insn=5 at IP=6.
- ROM {7,A,1,B,4}, accept 7, no skip at A, accept 1, SkipBack at IP=3 → one backscan to IP=1, next Insn=1 at IP=2; after InsnReady, IP=3 again.
- Handshake hold: RomAck delayed 3 cycles and InsnReady low 5 cycles → RomAddr and Insn stable throughout; no IP change until the accepting edge.
- Unmatched: ROM {A,1} with IP max=1 (ADDR_WIDTH=1), SkipFwd → Error=1; Start → Error=0, refetch at IP=0.
- Reset asserted during SKIP_B → all outputs 0 asynchronously; after release, state stays IDLE until Start.
